libv_deque_ctrl: RTL and testbench

- Initiator for the `libv_deque` command interface.
- Accepts independent valid/ready request streams for four operations: push-front, push-back, pop-front and pop-back.
- Arbitrates round-robin and issues at most one deque command per cycle on `cmd_vld`/`cmd_op`/`cmd_push_data`.
- Tracks occupancy, so the deque never sees a push when full or a pop when empty, and returns popped words on a registered valid/ready response channel.

---
 rtl/libv_pkg.sv | 11 +
 rtl/libv_deque_ctrl.sv | 169 ++++++++++++++++
 tb/tb_libv_deque_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/libv_pkg.sv
// libv_pkg: shared types for the libv deque family.
package libv_pkg;

  typedef enum logic [1:0] {
    OpPushFront = 2'd0,
    OpPushBack  = 2'd1,
    OpPopFront  = 2'd2,
    OpPopBack   = 2'd3
  } deque_op_t;

endpackage

// File: rtl/libv_deque_ctrl.sv
// libv_deque_ctrl: round-robin initiator for the libv_deque command interface.
// Four valid/ready request streams (push-front, push-back, pop-front, pop-back)
// share one deque command per cycle. The controller tracks occupancy so the deque
// never overflows or underflows. Popped words return on a registered response
// channel.
// Optional feature: define LIBV_DEQUE_CTRL_STALL_CNT_EN to add a saturating
// stall counter (stall_cnt_r) with a synchronous clear input (stall_cnt_clr).
module libv_deque_ctrl
  import libv_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pf_vld,
  input  logic [W-1:0]           pf_data,
  output logic                   pf_rdy,
  input  logic                   pb_vld,
  input  logic [W-1:0]           pb_data,
  output logic                   pb_rdy,
  input  logic                   qf_vld,
  output logic                   qf_rdy,
  input  logic                   qb_vld,
  output logic                   qb_rdy,
  output logic                   rsp_vld,
  output logic [W-1:0]           rsp_data,
  output logic                   rsp_back,
  input  logic                   rsp_rdy,
`ifdef LIBV_DEQUE_CTRL_STALL_CNT_EN
  input  logic                   stall_cnt_clr,
  output logic [15:0]            stall_cnt_r,
`endif
  output logic                   cmd_vld,
  output deque_op_t              cmd_op,
  output logic [W-1:0]           cmd_push_data,
  input  logic [W-1:0]           cmd_pop_data,
  output logic [$clog2(N):0]     occ_r,
  output logic                   empty_r,
  output logic                   full_r
);

  localparam int OW = $clog2(N) + 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(N);

  logic          rsp_slot_free;
  logic [3:0]    elig;
  logic [1:0]    rr_ptr;
  logic          grant_vld;
  logic [1:0]    grant_idx;
  logic [1:0]    cand;
  logic          push_grant;
  logic          pop_grant;
  logic [OW-1:0] occ_next;

  assign rsp_slot_free = !rsp_vld || rsp_rdy;

  // Eligibility per requester; index order pf, pb, qf, qb. Nothing is eligible in reset.
  always_comb begin
    elig[0] = !rst && pf_vld && (occ_r < OCC_MAX);
    elig[1] = !rst && pb_vld && (occ_r < OCC_MAX);
    elig[2] = !rst && qf_vld && (occ_r != '0) && rsp_slot_free;
    elig[3] = !rst && qb_vld && (occ_r != '0) && rsp_slot_free;
  end

  // Round-robin pick: scan downward so the candidate closest to the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign push_grant = grant_vld && !grant_idx[1];
  assign pop_grant  = grant_vld &&  grant_idx[1];

  // Decode the grant into ready strobes and the deque command.
  always_comb begin
    pf_rdy        = grant_vld && (grant_idx == 2'd0);
    pb_rdy        = grant_vld && (grant_idx == 2'd1);
    qf_rdy        = grant_vld && (grant_idx == 2'd2);
    qb_rdy        = grant_vld && (grant_idx == 2'd3);
    cmd_vld       = grant_vld;
    cmd_op        = OpPushFront;
    cmd_push_data = '0;
    if (grant_vld) begin
      case (grant_idx)
        2'd0: begin
          cmd_op        = OpPushFront;
          cmd_push_data = pf_data;
        end
        2'd1: begin
          cmd_op        = OpPushBack;
          cmd_push_data = pb_data;
        end
        2'd2: cmd_op = OpPopFront;
        default: cmd_op = OpPopBack;
      endcase
    end
  end

  // Next occupancy; the eligibility rules keep it inside 0..N, so no wrap handling.
  always_comb begin
    occ_next = occ_r;
    if (push_grant) begin
      occ_next = occ_r + OW'(1);
    end else if (pop_grant) begin
      occ_next = occ_r - OW'(1);
    end
  end

  // Occupancy and its registered empty/full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r   <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      occ_r   <= occ_next;
      empty_r <= (occ_next == '0);
      full_r  <= (occ_next == OCC_MAX);
    end
  end

  // Round-robin pointer moves just past the winner, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (grant_vld) begin
      rr_ptr <= grant_idx + 2'd1;
    end
  end

  // Response register: a new pop reloads it even while the old word is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
      rsp_back <= 1'b0;
    end else if (pop_grant) begin
      rsp_vld  <= 1'b1;
      rsp_data <= cmd_pop_data;
      rsp_back <= grant_idx[0];
    end else if (rsp_rdy) begin
      rsp_vld  <= 1'b0;
    end
  end

`ifdef LIBV_DEQUE_CTRL_STALL_CNT_EN
  logic any_vld;
  assign any_vld = pf_vld || pb_vld || qf_vld || qb_vld;

  // Count cycles with pending requests but no grant; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || stall_cnt_clr) begin
      stall_cnt_r <= 16'd0;
    end else if (any_vld && !grant_vld && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_libv_deque_ctrl.sv
// tb_libv_deque_ctrl: directed self-checking bench for libv_deque_ctrl (N=4, W=32),
// with a small behavioural deque answering the command interface.
module tb_libv_deque_ctrl;
  import libv_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         pf_vld, pb_vld, qf_vld, qb_vld;
  logic [W-1:0] pf_data, pb_data;
  logic         pf_rdy, pb_rdy, qf_rdy, qb_rdy;
  logic         rsp_vld, rsp_back, rsp_rdy;
  logic [W-1:0] rsp_data;
  logic         cmd_vld;
  deque_op_t    cmd_op;
  logic [W-1:0] cmd_push_data, cmd_pop_data;
  logic [2:0]   occ_r;
  logic         empty_r, full_r;
`ifdef LIBV_DEQUE_CTRL_STALL_CNT_EN
  logic         stall_cnt_clr;
  logic [15:0]  stall_cnt_r;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  libv_deque_ctrl #(.W(W), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .pf_vld        (pf_vld),
    .pf_data       (pf_data),
    .pf_rdy        (pf_rdy),
    .pb_vld        (pb_vld),
    .pb_data       (pb_data),
    .pb_rdy        (pb_rdy),
    .qf_vld        (qf_vld),
    .qf_rdy        (qf_rdy),
    .qb_vld        (qb_vld),
    .qb_rdy        (qb_rdy),
    .rsp_vld       (rsp_vld),
    .rsp_data      (rsp_data),
    .rsp_back      (rsp_back),
    .rsp_rdy       (rsp_rdy),
`ifdef LIBV_DEQUE_CTRL_STALL_CNT_EN
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt_r   (stall_cnt_r),
`endif
    .cmd_vld       (cmd_vld),
    .cmd_op        (cmd_op),
    .cmd_push_data (cmd_push_data),
    .cmd_pop_data  (cmd_pop_data),
    .occ_r         (occ_r),
    .empty_r       (empty_r),
    .full_r        (full_r)
  );

  // Behavioural deque: applies commands at the clock edge, exposes end words.
  logic [W-1:0] dq [$];
  logic [W-1:0] front_word = '0;
  logic [W-1:0] back_word  = '0;

  always @(posedge clk) begin
    if (rst) begin
      dq.delete();
    end else if (cmd_vld) begin
      case (cmd_op)
        OpPushFront: dq.push_front(cmd_push_data);
        OpPushBack:  dq.push_back(cmd_push_data);
        OpPopFront:  if (dq.size() > 0) void'(dq.pop_front());
        default:     if (dq.size() > 0) void'(dq.pop_back());
      endcase
    end
    front_word <= (dq.size() > 0) ? dq[0] : '0;
    back_word  <= (dq.size() > 0) ? dq[dq.size()-1] : '0;
  end

  assign cmd_pop_data = (cmd_op == OpPopBack) ? back_word : front_word;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic pf, input logic pb, input logic qf, input logic qb,
                               input logic [W-1:0] pfd, input logic [W-1:0] pbd);
    pf_vld  = pf;
    pb_vld  = pb;
    qf_vld  = qf;
    qb_vld  = qb;
    pf_data = pfd;
    pb_data = pbd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdyVec();
    return {28'd0, pf_rdy, pb_rdy, qf_rdy, qb_rdy};
  endfunction

  logic [3:0] rotExp [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [2:0] rotOcc [4] = '{3'd3, 3'd4, 3'd3, 3'd2};

  initial begin
    rst     = 1'b1;
    rsp_rdy = 1'b1;
`ifdef LIBV_DEQUE_CTRL_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    // Reset: requests are ignored while rst is high.
    applyStimulus(1, 0, 0, 0, 32'hA0, 0);
    checkOutput("rst_rdy", rdyVec(), 32'h0);
    checkOutput("rst_cmd_vld", 32'(cmd_vld), 32'h0);
    tick();
    tick();
    checkOutput("rst_occ", 32'(occ_r), 32'h0);
    checkOutput("rst_empty", 32'(empty_r), 32'h1);
    checkOutput("rst_full", 32'(full_r), 32'h0);
    checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_rsp_back", 32'(rsp_back), 32'h0);
    rst = 1'b0;

    // Fill with push-front A1..A4.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 32'hA1 + i, 0);
      checkOutput("push_rdy", rdyVec(), 32'h8);
      checkOutput("push_op", 32'(cmd_op), 32'(OpPushFront));
      checkOutput("push_data", cmd_push_data, 32'hA1 + i);
      tick();
      checkOutput("push_occ", 32'(occ_r), 32'(i + 1));
    end
    checkOutput("full_flag", 32'(full_r), 32'h1);
    checkOutput("full_empty", 32'(empty_r), 32'h0);
    applyStimulus(1, 0, 0, 0, 32'hA5, 0);
    checkOutput("full_stall_rdy", rdyVec(), 32'h0);
    checkOutput("full_stall_cmd", 32'(cmd_vld), 32'h0);
    tick();
    checkOutput("full_stall_occ", 32'(occ_r), 32'h4);

    // Drain with pop-front: newest front word first.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("popf_rdy", rdyVec(), 32'h2);
      checkOutput("popf_op", 32'(cmd_op), 32'(OpPopFront));
      tick();
      checkOutput("popf_rsp_vld", 32'(rsp_vld), 32'h1);
      checkOutput("popf_rsp_data", rsp_data, 32'hA4 - i);
      checkOutput("popf_rsp_back", 32'(rsp_back), 32'h0);
      checkOutput("popf_occ", 32'(occ_r), 32'(3 - i));
    end
    checkOutput("drain_empty", 32'(empty_r), 32'h1);
    checkOutput("drain_full", 32'(full_r), 32'h0);

    // Empty: pop-back stalls, response drains.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("empty_pop_rdy", rdyVec(), 32'h0);
      checkOutput("empty_pop_cmd", 32'(cmd_vld), 32'h0);
      tick();
      checkOutput("empty_rsp_vld", 32'(rsp_vld), 32'h0);
    end
    applyStimulus(0, 1, 0, 1, 0, 32'h55);
    checkOutput("pb55_rdy", rdyVec(), 32'h4);
    tick();
    checkOutput("pb55_occ", 32'(occ_r), 32'h1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("qb55_rdy", rdyVec(), 32'h1);
    checkOutput("qb55_op", 32'(cmd_op), 32'(OpPopBack));
    checkOutput("qb55_pdata", cmd_push_data, 32'h0);
    tick();
    checkOutput("qb55_rsp_data", rsp_data, 32'h55);
    checkOutput("qb55_rsp_back", 32'(rsp_back), 32'h1);
    checkOutput("qb55_occ", 32'(occ_r), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rsp_clear", 32'(rsp_vld), 32'h0);

    // Build occ=2 with the pointer back at pf: pf C1, pf C2, pb C3, qb -> C3.
    applyStimulus(1, 0, 0, 0, 32'hC1, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 32'hC2, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 32'hC3);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("prep_qb_rdy", rdyVec(), 32'h1);
    tick();
    checkOutput("prep_rsp_data", rsp_data, 32'hC3);
    checkOutput("prep_occ", 32'(occ_r), 32'h2);

    // All four valid: grants rotate pf, pb, qf, qb.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 1, 32'hD1, 32'hD2);
      checkOutput("rot_rdy", rdyVec(), 32'(rotExp[i]));
      tick();
      checkOutput("rot_occ", 32'(occ_r), 32'(rotOcc[i]));
      if (i == 2) begin
        checkOutput("rot_qf_data", rsp_data, 32'hD1);
        checkOutput("rot_qf_back", 32'(rsp_back), 32'h0);
      end
      if (i == 3) begin
        checkOutput("rot_qb_data", rsp_data, 32'hD2);
        checkOutput("rot_qb_back", 32'(rsp_back), 32'h1);
      end
    end

    // Response stalled: pops wait, pushes proceed.
    rsp_rdy = 1'b0;
    applyStimulus(0, 1, 1, 0, 0, 32'hE1);
    checkOutput("stall_push_rdy", rdyVec(), 32'h4);
    tick();
    checkOutput("stall_push_occ", 32'(occ_r), 32'h3);
    checkOutput("stall_hold_data", rsp_data, 32'hD2);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("stall_pop_rdy", rdyVec(), 32'h0);
    checkOutput("stall_pop_cmd", 32'(cmd_vld), 32'h0);
    tick();
    checkOutput("stall_rsp_vld", 32'(rsp_vld), 32'h1);
    checkOutput("stall_rsp_data", rsp_data, 32'hD2);
    rsp_rdy = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("unstall_rdy", rdyVec(), 32'h2);
    tick();
    checkOutput("unstall_data", rsp_data, 32'hC2);
    checkOutput("unstall_occ", 32'(occ_r), 32'h2);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("b2b_rdy", rdyVec(), 32'h2);
    tick();
    checkOutput("b2b_vld", 32'(rsp_vld), 32'h1);
    checkOutput("b2b_data", rsp_data, 32'hC1);
    checkOutput("b2b_occ", 32'(occ_r), 32'h1);

    // Hold the response and refill to occ=3; last grant pf leaves pointer at pb.
    rsp_rdy = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, 32'hF1);
    checkOutput("refill_pb_rdy", rdyVec(), 32'h4);
    tick();
    applyStimulus(1, 0, 0, 0, 32'hF2, 0);
    checkOutput("refill_pf_rdy", rdyVec(), 32'h8);
    tick();
    checkOutput("refill_occ", 32'(occ_r), 32'h3);
    checkOutput("refill_rsp_vld", 32'(rsp_vld), 32'h1);

    // Mid-operation reset discards response and occupancy.
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 32'hF3, 0);
    checkOutput("mrst_rdy", rdyVec(), 32'h0);
    checkOutput("mrst_cmd", 32'(cmd_vld), 32'h0);
    tick();
    checkOutput("mrst_rsp_vld", 32'(rsp_vld), 32'h0);
    checkOutput("mrst_rsp_data", rsp_data, 32'h0);
    checkOutput("mrst_occ", 32'(occ_r), 32'h0);
    checkOutput("mrst_empty", 32'(empty_r), 32'h1);
    rst = 1'b0;
    rsp_rdy = 1'b1;

`ifdef LIBV_DEQUE_CTRL_STALL_CNT_EN
    checkOutput("stall_cnt_rst", 32'(stall_cnt_r), 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("stall_cnt_5", 32'(stall_cnt_r), 32'h5);
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    checkOutput("stall_cnt_clr", 32'(stall_cnt_r), 32'h0);
`endif

    // Pointer must be back at pf after reset.
    applyStimulus(1, 1, 0, 0, 32'hB1, 32'hB2);
    checkOutput("ptr_rst_rdy", rdyVec(), 32'h8);
    tick();
    checkOutput("ptr_rst_occ", 32'(occ_r), 32'h1);
    applyStimulus(0, 1, 0, 0, 0, 32'hB2);
    checkOutput("ptr_next_rdy", rdyVec(), 32'h4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
